// File: rtl/fsm_control_pkg.sv
// Shared definitions for the FIFO switching-stage control FSM: state encodings and threshold defaults.
package fsm_control_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'b000,
        ST_INIT   = 3'b001,
        ST_IDLE   = 3'b010,
        ST_ACTIVE = 3'b011,
        ST_ERROR  = 3'b100
    } state_t;

    localparam int UMB_BAJO_RST = 1;
    localparam int UMB_ALTO_RST = 6;

endpackage

// File: rtl/fsm_control_umbral_regs.sv
// Almost-empty/almost-full threshold registers; only an ordered pair (bajo < alto) is ever accepted.
module fsm_control_umbral_regs #(
    parameter int TH_W     = 3,
    parameter int BAJO_DEF = 1,
    parameter int ALTO_DEF = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_en,
    input  logic [TH_W-1:0] bajo_in,
    input  logic [TH_W-1:0] alto_in,
    output logic [TH_W-1:0] bajo_out,
    output logic [TH_W-1:0] alto_out
);

    logic pair_ok;

    assign pair_ok = (bajo_in < alto_in);

    // Both values move together so the outputs can never show an inverted pair.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bajo_out <= TH_W'(BAJO_DEF);
            alto_out <= TH_W'(ALTO_DEF);
        end else if (load_en && pair_ok) begin
            bajo_out <= bajo_in;
            alto_out <= alto_in;
        end
    end

endmodule

// File: rtl/fsm_control.sv
// Main control FSM of the FIFO switching stage: idle/error flags and programmable thresholds.
// Optional ERR_SRC_CAPTURE_EN records which FIFOs drove the machine into ERROR.
module fsm_control
    import fsm_control_pkg::*;
#(
    parameter int NUM_FIFOS    = 4,
    parameter int TH_W         = 3,
    parameter int UMB_BAJO_DEF = UMB_BAJO_RST,
    parameter int UMB_ALTO_DEF = UMB_ALTO_RST
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [TH_W-1:0]      umbral_bajo_in,
    input  logic [TH_W-1:0]      umbral_alto_in,
    input  logic [NUM_FIFOS-1:0] empty,
    input  logic [NUM_FIFOS-1:0] error,
    output logic [TH_W-1:0]      umbral_bajo_out,
    output logic [TH_W-1:0]      umbral_alto_out,
    output logic [2:0]           state,
    output logic [2:0]           next_state,
    output logic                 idle,
    output logic                 error_out,
    output logic [NUM_FIFOS-1:0] err_src
);

    state_t state_q, state_d;
    logic   any_err, all_empty;

    assign any_err   = |error;
    assign all_empty = &empty;

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    // Reset is folded in here so next_state reads RESET while reset is held.
    always_comb begin
        state_d = state_q;
        if (!reset) begin
            state_d = ST_RESET;
        end else begin
            case (state_q)
                ST_RESET:  state_d = ST_INIT;
                ST_INIT:   if (any_err)        state_d = ST_ERROR;
                           else if (init)      state_d = ST_INIT;
                           else                state_d = ST_IDLE;
                ST_IDLE:   if (any_err)        state_d = ST_ERROR;
                           else if (init)      state_d = ST_INIT;
                           else if (!all_empty) state_d = ST_ACTIVE;
                           else                state_d = ST_IDLE;
                ST_ACTIVE: if (any_err)        state_d = ST_ERROR;
                           else if (init)      state_d = ST_INIT;
                           else if (all_empty) state_d = ST_IDLE;
                           else                state_d = ST_ACTIVE;
                ST_ERROR:  state_d = ST_ERROR;
                default:   state_d = ST_RESET;
            endcase
        end
    end

    assign state      = state_q;
    assign next_state = state_d;
    assign idle       = (state_q == ST_IDLE);
    assign error_out  = (state_q == ST_ERROR);

    fsm_control_umbral_regs #(
        .TH_W     (TH_W),
        .BAJO_DEF (UMB_BAJO_DEF),
        .ALTO_DEF (UMB_ALTO_DEF)
    ) u_umbral_regs (
        .clk      (clk),
        .reset    (reset),
        .load_en  (state_q == ST_INIT),
        .bajo_in  (umbral_bajo_in),
        .alto_in  (umbral_alto_in),
        .bajo_out (umbral_bajo_out),
        .alto_out (umbral_alto_out)
    );

`ifdef ERR_SRC_CAPTURE_EN
    logic [NUM_FIFOS-1:0] err_src_q;

    // Snapshot on entry, then accumulate any later offenders until reset.
    always_ff @(posedge clk) begin
        if (!reset)
            err_src_q <= '0;
        else if (state_q == ST_ERROR)
            err_src_q <= err_src_q | error;
        else if (state_d == ST_ERROR)
            err_src_q <= error;
    end

    assign err_src = err_src_q;
`else
    assign err_src = '0;
`endif

endmodule

// File: tb/tb_fsm_control.sv
// Directed self-checking bench for fsm_control (honours ERR_SRC_CAPTURE_EN when defined).
module tb_fsm_control;
    import fsm_control_pkg::*;

    logic       clk = 1'b0;
    logic       reset, init;
    logic [2:0] bajo_in, alto_in;
    logic [3:0] empty, error;
    logic [2:0] bajo_out, alto_out, state, next_state;
    logic       idle, error_out;
    logic [3:0] err_src;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ERR_SRC_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    fsm_control dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .umbral_bajo_in  (bajo_in),
        .umbral_alto_in  (alto_in),
        .empty           (empty),
        .error           (error),
        .umbral_bajo_out (bajo_out),
        .umbral_alto_out (alto_out),
        .state           (state),
        .next_state      (next_state),
        .idle            (idle),
        .error_out       (error_out),
        .err_src         (err_src)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_src(input logic [3:0] v);
        return CAP ? v : 4'b0000;
    endfunction

    task automatic test_reset();
        reset = 1'b0; init = 1'b0; bajo_in = 3'd0; alto_in = 3'd0;
        empty = 4'hF; error = 4'h0;
        tick(); tick();
        n_checks++; if (state !== 3'b000) begin n_fail++; $display("FAIL reset_state got %b exp 000", state); end
        n_checks++; if (next_state !== 3'b000) begin n_fail++; $display("FAIL reset_next got %b exp 000", next_state); end
        n_checks++; if (idle !== 1'b0 || error_out !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b exp 00", idle, error_out); end
        n_checks++; if (bajo_out !== 3'd1 || alto_out !== 3'd6) begin n_fail++; $display("FAIL reset_th got %0d/%0d exp 1/6", bajo_out, alto_out); end
        n_checks++; if (err_src !== 4'b0000) begin n_fail++; $display("FAIL reset_src got %b exp 0000", err_src); end
        reset = 1'b1;
        #1;
        n_checks++; if (next_state !== 3'b001) begin n_fail++; $display("FAIL rel_next got %b exp 001", next_state); end
        tick();
        n_checks++; if (state !== 3'b001) begin n_fail++; $display("FAIL to_init got %b exp 001", state); end
        tick();
        n_checks++; if (state !== 3'b010 || idle !== 1'b1) begin n_fail++; $display("FAIL to_idle got %b idle %b exp 010 1", state, idle); end
        n_checks++; if (bajo_out !== 3'd1 || alto_out !== 3'd6) begin n_fail++; $display("FAIL init_noload got %0d/%0d exp 1/6", bajo_out, alto_out); end
    endtask

    task automatic test_thresholds();
        init = 1'b1; bajo_in = 3'd2; alto_in = 3'd5;
        tick();
        n_checks++; if (state !== 3'b001 || idle !== 1'b0) begin n_fail++; $display("FAIL th_enter got %b idle %b exp 001 0", state, idle); end
        tick();
        n_checks++; if (bajo_out !== 3'd2 || alto_out !== 3'd5) begin n_fail++; $display("FAIL th_load got %0d/%0d exp 2/5", bajo_out, alto_out); end
        bajo_in = 3'd6; alto_in = 3'd3;
        tick();
        n_checks++; if (bajo_out !== 3'd2 || alto_out !== 3'd5) begin n_fail++; $display("FAIL th_reject got %0d/%0d exp 2/5", bajo_out, alto_out); end
        bajo_in = 3'd4; alto_in = 3'd4;
        tick();
        n_checks++; if (bajo_out !== 3'd2 || alto_out !== 3'd5) begin n_fail++; $display("FAIL th_equal got %0d/%0d exp 2/5", bajo_out, alto_out); end
        init = 1'b0; bajo_in = 3'd0; alto_in = 3'd7;
        tick();
        n_checks++; if (state !== 3'b010 || idle !== 1'b1) begin n_fail++; $display("FAIL th_exit got %b idle %b exp 010 1", state, idle); end
        // last INIT edge sampled 0/7, which is a valid pair
        n_checks++; if (bajo_out !== 3'd0 || alto_out !== 3'd7) begin n_fail++; $display("FAIL th_last got %0d/%0d exp 0/7", bajo_out, alto_out); end
        bajo_in = 3'd1; alto_in = 3'd2;
        tick();
        n_checks++; if (bajo_out !== 3'd0 || alto_out !== 3'd7) begin n_fail++; $display("FAIL th_frozen got %0d/%0d exp 0/7", bajo_out, alto_out); end
    endtask

    task automatic test_active();
        empty = 4'b1011;
        tick();
        n_checks++; if (state !== 3'b011 || idle !== 1'b0) begin n_fail++; $display("FAIL to_active got %b idle %b exp 011 0", state, idle); end
        empty = 4'hF;
        tick();
        n_checks++; if (state !== 3'b010 || idle !== 1'b1) begin n_fail++; $display("FAIL back_idle got %b idle %b exp 010 1", state, idle); end
    endtask

    task automatic test_error_sticky();
        empty = 4'b1011;
        tick();
        n_checks++; if (state !== 3'b011) begin n_fail++; $display("FAIL err_pre got %b exp 011", state); end
        error = 4'b0100; init = 1'b1;
        tick();
        n_checks++; if (state !== 3'b100 || error_out !== 1'b1) begin n_fail++; $display("FAIL err_enter got %b eo %b exp 100 1", state, error_out); end
        n_checks++; if (err_src !== exp_src(4'b0100)) begin n_fail++; $display("FAIL err_src1 got %b exp %b", err_src, exp_src(4'b0100)); end
        error = 4'h0; init = 1'b0; empty = 4'hF;
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (state !== 3'b100 || error_out !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b eo %b exp 100 1", state, error_out); end
        error = 4'b0001;
        tick();
        error = 4'h0;
        n_checks++; if (err_src !== exp_src(4'b0101)) begin n_fail++; $display("FAIL err_src2 got %b exp %b", err_src, exp_src(4'b0101)); end
        reset = 1'b0;
        tick();
        n_checks++; if (state !== 3'b000 || error_out !== 1'b0) begin n_fail++; $display("FAIL err_reset got %b eo %b exp 000 0", state, error_out); end
        n_checks++; if (err_src !== 4'b0000) begin n_fail++; $display("FAIL err_src_clr got %b exp 0000", err_src); end
        n_checks++; if (bajo_out !== 3'd1 || alto_out !== 3'd6) begin n_fail++; $display("FAIL err_th got %0d/%0d exp 1/6", bajo_out, alto_out); end
        // error while in RESET must be ignored
        reset = 1'b1; error = 4'hF; bajo_in = 3'd0; alto_in = 3'd0;
        tick();
        n_checks++; if (state !== 3'b001) begin n_fail++; $display("FAIL rst_ignore got %b exp 001", state); end
        error = 4'h0;
        tick();
        n_checks++; if (state !== 3'b010 || idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle got %b idle %b exp 010 1", state, idle); end
    endtask

    task automatic test_init_vs_error();
        init = 1'b1;
        tick();
        n_checks++; if (state !== 3'b001 || idle !== 1'b0) begin n_fail++; $display("FAIL reinit got %b idle %b exp 001 0", state, idle); end
        error = 4'b1000;
        #1;
        n_checks++; if (next_state !== 3'b100) begin n_fail++; $display("FAIL prio_next got %b exp 100", next_state); end
        tick();
        n_checks++; if (state !== 3'b100 || error_out !== 1'b1) begin n_fail++; $display("FAIL prio got %b eo %b exp 100 1", state, error_out); end
        n_checks++; if (err_src !== exp_src(4'b1000)) begin n_fail++; $display("FAIL prio_src got %b exp %b", err_src, exp_src(4'b1000)); end
        error = 4'h0; init = 1'b0;
    endtask

    initial begin
        test_reset();
        test_thresholds();
        test_active();
        test_error_sticky();
        test_init_vs_error();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
